// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-side inputs and ID/EX control bundle of the pipelined PCPU control stage
// Purpose : groups every ctrl_pipe handshake/bus signal except clk and rstn.
// master  : the pipeline around the block; drives id_valid, Op, Funct7, Funct3, rs1, rs2, rd, flush.
// slave   : ctrl_pipe; drives stall, mdu_start, mdu_busy and the registered ex_* bundle.
interface ctrl_pipe_if;
   logic       id_valid;
   logic [6:0] Op;
   logic [6:0] Funct7;
   logic [2:0] Funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;
   logic       flush;

   logic       stall;
   logic       mdu_start;
   logic       mdu_busy;
   logic       ex_RegWrite;
   logic       ex_MemWrite;
   logic       ex_MemRead;
   logic       ex_ALUSrc;
   logic [5:0] ex_EXTOp;
   logic [4:0] ex_ALUOp;
   logic [2:0] ex_NPCOp;
   logic [1:0] ex_WDSel;
   logic [2:0] ex_DMType;
   logic [2:0] ex_mdu_op;
   logic       ex_is_mdu;
   logic [4:0] ex_rd;
   logic       ex_illegal;

   modport master (
      output id_valid, Op, Funct7, Funct3, rs1, rs2, rd, flush,
      input  stall, mdu_start, mdu_busy, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
             ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, ex_mdu_op, ex_is_mdu,
             ex_rd, ex_illegal
   );

   modport slave (
      input  id_valid, Op, Funct7, Funct3, rs1, rs2, rd, flush,
      output stall, mdu_start, mdu_busy, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc,
             ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_DMType, ex_mdu_op, ex_is_mdu,
             ex_rd, ex_illegal
   );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX control decode, load-use hazard detection and MUL/DIV sequencing
// Purpose : decodes the ID instruction (RV32I, optional RV32M) into the registered EX control bundle,
//           inserts bubbles on flush / load-use, and holds EX for multi-cycle M-ops.
// Ports   : clk  - rising-edge clock
//           rstn - synchronous active-low reset
//           bus  - ctrl_pipe_if.slave (ID fields and flush in; stall, mdu_start, mdu_busy, ex_* out)
module ctrl_pipe #(
   parameter int ENABLE_M = 1,
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 17,
   parameter int CNT_W    = 6
) (
   input logic        clk,
   input logic        rstn,
   ctrl_pipe_if.slave bus
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MDU  = 7'b0000001;

   localparam logic [4:0] ALU_LUI   = 5'b00001;
   localparam logic [4:0] ALU_AUIPC = 5'b00010;
   localparam logic [4:0] ALU_ADD   = 5'b00011;
   localparam logic [4:0] ALU_SUB   = 5'b00100;
   localparam logic [4:0] ALU_BNE   = 5'b00101;
   localparam logic [4:0] ALU_BLT   = 5'b00110;
   localparam logic [4:0] ALU_BGE   = 5'b00111;
   localparam logic [4:0] ALU_BLTU  = 5'b01000;
   localparam logic [4:0] ALU_BGEU  = 5'b01001;
   localparam logic [4:0] ALU_SLT   = 5'b01010;
   localparam logic [4:0] ALU_SLTU  = 5'b01011;
   localparam logic [4:0] ALU_XOR   = 5'b01100;
   localparam logic [4:0] ALU_OR    = 5'b01101;
   localparam logic [4:0] ALU_AND   = 5'b01110;
   localparam logic [4:0] ALU_SLL   = 5'b01111;
   localparam logic [4:0] ALU_SRL   = 5'b10000;
   localparam logic [4:0] ALU_SRA   = 5'b10001;

   localparam logic [5:0] EXT_SHAMT = 6'b100000;
   localparam logic [5:0] EXT_I     = 6'b010000;
   localparam logic [5:0] EXT_S     = 6'b001000;
   localparam logic [5:0] EXT_B     = 6'b000100;
   localparam logic [5:0] EXT_U     = 6'b000010;
   localparam logic [5:0] EXT_J     = 6'b000001;

   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_JALR   = 3'b100;

   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   localparam logic [2:0] DM_W  = 3'b000;
   localparam logic [2:0] DM_H  = 3'b001;
   localparam logic [2:0] DM_HU = 3'b010;
   localparam logic [2:0] DM_B  = 3'b011;
   localparam logic [2:0] DM_BU = 3'b100;

   // BUSY is entered on the M-op's first EX cycle, so the counter starts at L-2
   // and the exit edge is the L-th EX cycle.
   localparam logic             MUL_MULTI = (MUL_LAT > 1);
   localparam logic             DIV_MULTI = (DIV_LAT > 1);
   localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic [5:0] ext_op;
      logic [4:0] alu_op;
      logic [2:0] npc_op;
      logic [1:0] wd_sel;
      logic [2:0] dm_type;
      logic [2:0] mdu_op;
      logic       is_mdu;
      logic [4:0] rd;
      logic       illegal;
   } bundle_t;

   typedef enum logic {S_RUN, S_BUSY} state_t;

   bundle_t          dec;
   bundle_t          ex;
   logic             dec_bad;
   logic             uses_rs1;
   logic             uses_rs2;
   logic             lu;
   logic             dec_multi;
   logic [CNT_W-1:0] dec_cnt;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mdu_start_r;
   logic             mdu_busy_r;

   always_comb begin
      dec      = '0;
      dec_bad  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (bus.Op)
         OP_R: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec.reg_write = 1'b1;
            if (bus.Funct7 == F7_MDU) begin
               if (ENABLE_M != 0) begin
                  dec.is_mdu = 1'b1;
                  dec.mdu_op = bus.Funct3;
               end else begin
                  dec_bad = 1'b1;
               end
            end else if (bus.Funct7 == F7_BASE) begin
               case (bus.Funct3)
                  3'b000:  dec.alu_op = ALU_ADD;
                  3'b001:  dec.alu_op = ALU_SLL;
                  3'b010:  dec.alu_op = ALU_SLT;
                  3'b011:  dec.alu_op = ALU_SLTU;
                  3'b100:  dec.alu_op = ALU_XOR;
                  3'b101:  dec.alu_op = ALU_SRL;
                  3'b110:  dec.alu_op = ALU_OR;
                  default: dec.alu_op = ALU_AND;
               endcase
            end else if (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b000) begin
               dec.alu_op = ALU_SUB;
            end else if (bus.Funct7 == F7_ALT && bus.Funct3 == 3'b101) begin
               dec.alu_op = ALU_SRA;
            end else begin
               dec_bad = 1'b1;
            end
         end
         OP_I: begin
            uses_rs1      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_I;
            case (bus.Funct3)
               3'b000: dec.alu_op = ALU_ADD;
               3'b010: dec.alu_op = ALU_SLT;
               3'b011: dec.alu_op = ALU_SLTU;
               3'b100: dec.alu_op = ALU_XOR;
               3'b110: dec.alu_op = ALU_OR;
               3'b111: dec.alu_op = ALU_AND;
               3'b001: begin
                  dec.ext_op = EXT_SHAMT;
                  dec.alu_op = ALU_SLL;
                  dec_bad    = (bus.Funct7 != F7_BASE);
               end
               default: begin
                  dec.ext_op = EXT_SHAMT;
                  if (bus.Funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
                  else if (bus.Funct7 == F7_ALT) dec.alu_op = ALU_SRA;
                  else                           dec_bad    = 1'b1;
               end
            endcase
         end
         OP_L: begin
            uses_rs1      = 1'b1;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_I;
            dec.alu_op    = ALU_ADD;
            dec.wd_sel    = WD_MEM;
            case (bus.Funct3)
               3'b000:  dec.dm_type = DM_B;
               3'b001:  dec.dm_type = DM_H;
               3'b010:  dec.dm_type = DM_W;
               3'b100:  dec.dm_type = DM_BU;
               3'b101:  dec.dm_type = DM_HU;
               default: dec_bad     = 1'b1;
            endcase
         end
         OP_S: begin
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_S;
            dec.alu_op    = ALU_ADD;
            case (bus.Funct3)
               3'b000:  dec.dm_type = DM_B;
               3'b001:  dec.dm_type = DM_H;
               3'b010:  dec.dm_type = DM_W;
               default: dec_bad     = 1'b1;
            endcase
         end
         OP_B: begin
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
            dec.ext_op = EXT_B;
            dec.npc_op = NPC_BRANCH;
            case (bus.Funct3)
               3'b000:  dec.alu_op = ALU_SUB;
               3'b001:  dec.alu_op = ALU_BNE;
               3'b100:  dec.alu_op = ALU_BLT;
               3'b101:  dec.alu_op = ALU_BGE;
               3'b110:  dec.alu_op = ALU_BLTU;
               3'b111:  dec.alu_op = ALU_BGEU;
               default: dec_bad    = 1'b1;
            endcase
         end
         OP_JAL: begin
            dec.reg_write = 1'b1;
            dec.ext_op    = EXT_J;
            dec.npc_op    = NPC_JUMP;
            dec.wd_sel    = WD_PC;
         end
         OP_JALR: begin
            uses_rs1      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_I;
            dec.alu_op    = ALU_ADD;
            dec.npc_op    = NPC_JALR;
            dec.wd_sel    = WD_PC;
            dec_bad       = (bus.Funct3 != 3'b000);
         end
         OP_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_U;
            dec.alu_op    = ALU_LUI;
         end
         OP_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.ext_op    = EXT_U;
            dec.alu_op    = ALU_AUIPC;
         end
         default: dec_bad = 1'b1;
      endcase
      dec.rd = bus.rd;
      // An undecodable instruction travels down as a bubble carrying only the illegal flag.
      if (dec_bad) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   // Funct3[2] separates div/divu/rem/remu from the multiplies.
   assign dec_multi = bus.Funct3[2] ? DIV_MULTI : MUL_MULTI;
   assign dec_cnt   = bus.Funct3[2] ? DIV_CNT : MUL_CNT;

   assign lu = bus.id_valid & ex.mem_read & (ex.rd != 5'd0) &
               ((uses_rs1 & (bus.rs1 == ex.rd)) | (uses_rs2 & (bus.rs2 == ex.rd)));

   // A flush in RUN discards the ID instruction, so a coincident load-use must not freeze IF/ID.
   assign bus.stall = ((state == S_RUN) & lu & ~bus.flush) | (state == S_BUSY);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ex          <= '0;
         state       <= S_RUN;
         cnt         <= '0;
         mdu_start_r <= 1'b0;
         mdu_busy_r  <= 1'b0;
      end else begin
         mdu_start_r <= 1'b0;
         case (state)
            S_RUN: begin
               if (bus.flush || !bus.id_valid || lu) begin
                  ex <= '0;
               end else begin
                  ex <= dec;
                  if (dec.is_mdu) begin
                     mdu_start_r <= 1'b1;
                     if (dec_multi) begin
                        state      <= S_BUSY;
                        mdu_busy_r <= 1'b1;
                        cnt        <= dec_cnt;
                     end
                  end
               end
            end
            default: begin
               if (bus.flush) begin
                  ex         <= '0;
                  state      <= S_RUN;
                  cnt        <= '0;
                  mdu_busy_r <= 1'b0;
               end else if (cnt == '0) begin
                  state      <= S_RUN;
                  mdu_busy_r <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.mdu_start   = mdu_start_r;
   assign bus.mdu_busy    = mdu_busy_r;
   assign bus.ex_RegWrite = ex.reg_write;
   assign bus.ex_MemWrite = ex.mem_write;
   assign bus.ex_MemRead  = ex.mem_read;
   assign bus.ex_ALUSrc   = ex.alu_src;
   assign bus.ex_EXTOp    = ex.ext_op;
   assign bus.ex_ALUOp    = ex.alu_op;
   assign bus.ex_NPCOp    = ex.npc_op;
   assign bus.ex_WDSel    = ex.wd_sel;
   assign bus.ex_DMType   = ex.dm_type;
   assign bus.ex_mdu_op   = ex.mdu_op;
   assign bus.ex_is_mdu   = ex.is_mdu;
   assign bus.ex_rd       = ex.rd;
   assign bus.ex_illegal  = ex.illegal;

endmodule
